// File: rtl/y86_regfile.sv
// Y86 register file: 15 x DATA_W registers, two combinational read ports,
// two writeback ports (E from execute, M from memory) with M priority on a
// collision, a committed-write counter and a registered E/M collision flag.
module y86_regfile #(
    parameter int          DATA_W = 64,
    parameter logic [3:0]  RNONE  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        srcA,
    input  logic [3:0]        srcB,
    input  logic [3:0]        dstE,
    input  logic [DATA_W-1:0] valE,
    input  logic [3:0]        dstM,
    input  logic [DATA_W-1:0] valM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    output logic [15:0]       wr_cnt,
    output logic              conflict
);

    localparam int NREG = 15;

    logic [DATA_W-1:0] regs [0:NREG-1];

    // An ID is a real write target only if it is not RNONE and names one of
    // the 15 physical registers.
    logic e_vld, m_vld, same_dst;
    logic [1:0]  wr_num;
    logic [15:0] wr_add;

    // Write-port qualification and number of distinct registers written.
    always_comb begin
        e_vld    = (dstE != RNONE) && (dstE < 4'(NREG));
        m_vld    = (dstM != RNONE) && (dstM < 4'(NREG));
        same_dst = e_vld && m_vld && (dstE == dstM);
        wr_num   = 2'(e_vld) + 2'(m_vld) - 2'(same_dst);
        wr_add   = {14'd0, wr_num};
    end

    // Per-register storage; reset dominates, then M wins over E.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst)
                regs[i] <= '0;
            else if (wr_en && m_vld && (dstM == 4'(i)))
                regs[i] <= valM;
            else if (wr_en && e_vld && (dstE == 4'(i)))
                regs[i] <= valE;
        end
    end

    // Commit counter (wraps freely) and collision flag, both held when wr_en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt   <= '0;
            conflict <= 1'b0;
        end else if (wr_en) begin
            wr_cnt   <= wr_cnt + wr_add;
            conflict <= same_dst;
        end
    end

    // Combinational reads of pre-edge contents; RNONE or an unmapped ID reads 0.
    always_comb begin
        valA = '0;
        valB = '0;
        if (srcA != RNONE && srcA < 4'(NREG)) valA = regs[srcA];
        if (srcB != RNONE && srcB < 4'(NREG)) valB = regs[srcB];
    end

endmodule

// File: tb/tb_y86_regfile.sv
// Self-checking bench for y86_regfile: directed scenarios plus a randomized
// run, all compared against an array-based architectural model.
module tb_y86_regfile;

    logic        clk = 1'b0;
    logic        rst, wr_en;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valE, valM, valA, valB;
    logic [15:0] wr_cnt;
    logic        conflict;

    int checks = 0;
    int errors = 0;

    // Architectural model: register array, commit count, last collision.
    logic [63:0] m_reg [15];
    int          m_cnt;
    logic        m_conf;

    y86_regfile #(.DATA_W(64), .RNONE(4'hF)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en),
        .srcA(srcA), .srcB(srcB),
        .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
        .valA(valA), .valB(valB), .wr_cnt(wr_cnt), .conflict(conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_rd(input logic [3:0] id);
        return (id == 4'hF) ? 64'd0 : m_reg[id];
    endfunction

    // Apply one clock edge to the model using the currently driven inputs.
    function automatic void model_edge();
        int n;
        if (rst) begin
            for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
            m_cnt  = 0;
            m_conf = 1'b0;
        end else if (wr_en) begin
            n = 0;
            if (dstE != 4'hF) begin m_reg[dstE] = valE; n++; end
            if (dstM != 4'hF) begin
                m_reg[dstM] = valM;
                if (dstM != dstE) n++;
            end
            m_cnt  = (m_cnt + n) % 65536;
            m_conf = (dstE != 4'hF) && (dstE == dstM);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rst = 1'b0;
        dstE = 4'hF; dstM = 4'hF; valE = '0; valM = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b1; dstE = 4'd2; dstM = 4'd9;
        valE = 64'h55; valM = 64'h66;
        tick();
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i); srcB = 4'(15 - i);
            #1;
            checks++;
            if (valA !== 64'd0 || valB !== 64'd0) begin
                errors++;
                $display("FAIL reset_read id=%0d valA=%h valB=%h want 0", i, valA, valB);
            end
        end
        checks++;
        if (wr_cnt !== 16'd0 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_state wr_cnt=%0d conflict=%b want 0/0", wr_cnt, conflict);
        end
    endtask

    task automatic test_basic();
        wr_en = 1'b1; dstE = 4'd0; valE = 64'h1234; dstM = 4'd3; valM = 64'hABCD;
        tick();
        idle();
        srcA = 4'd0; srcB = 4'd3;
        #1;
        checks++;
        if (valA !== 64'h1234 || valB !== 64'hABCD) begin
            errors++;
            $display("FAIL basic_read valA=%h valB=%h want 1234/abcd", valA, valB);
        end
        checks++;
        if (wr_cnt !== 16'd2 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL basic_cnt wr_cnt=%0d conflict=%b want 2/0", wr_cnt, conflict);
        end
    endtask

    task automatic test_conflict();
        wr_en = 1'b1; dstE = 4'd4; valE = 64'd5; dstM = 4'd4; valM = 64'd9;
        tick();
        idle();
        srcA = 4'd4; srcB = 4'd4;
        #1;
        checks++;
        if (valA !== 64'd9 || valB !== 64'd9) begin
            errors++;
            $display("FAIL conflict_data valA=%h valB=%h want 9", valA, valB);
        end
        checks++;
        if (wr_cnt !== 16'd3 || conflict !== 1'b1) begin
            errors++;
            $display("FAIL conflict_flag wr_cnt=%0d conflict=%b want 3/1", wr_cnt, conflict);
        end
    endtask

    task automatic test_no_bypass();
        srcA = 4'd7; wr_en = 1'b1; dstE = 4'd7; valE = 64'hFF; dstM = 4'hF;
        #1;
        checks++;
        if (valA !== 64'd0) begin
            errors++;
            $display("FAIL no_bypass_pre valA=%h want 0", valA);
        end
        tick();
        idle();
        checks++;
        if (valA !== 64'hFF || wr_cnt !== 16'd4 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL no_bypass_post valA=%h cnt=%0d conf=%b want ff/4/0", valA, wr_cnt, conflict);
        end
    endtask

    task automatic test_wr_en_low();
        wr_en = 1'b1; dstE = 4'd2; valE = 64'd1; dstM = 4'd2; valM = 64'd2;
        tick();
        wr_en = 1'b0; dstE = 4'd1; valE = 64'd77; dstM = 4'd6; valM = 64'd88;
        tick();
        tick();
        idle();
        srcA = 4'd1; srcB = 4'd6;
        #1;
        checks++;
        if (valA !== 64'd0 || valB !== 64'd0) begin
            errors++;
            $display("FAIL wr_en_low_data valA=%h valB=%h want 0/0", valA, valB);
        end
        checks++;
        if (wr_cnt !== 16'd5 || conflict !== 1'b1) begin
            errors++;
            $display("FAIL wr_en_low_hold wr_cnt=%0d conflict=%b want 5/1", wr_cnt, conflict);
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        for (int it = 0; it < 400; it++) begin
            rst   = ($urandom_range(0, 39) == 0);
            wr_en = ($urandom_range(0, 3) != 0);
            d = 4'($urandom_range(0, 18) > 15 ? 15 : $urandom_range(0, 15));
            dstE = d;
            d = 4'($urandom_range(0, 18) > 15 ? 15 : $urandom_range(0, 15));
            dstM = ($urandom_range(0, 4) == 0) ? dstE : d;
            valE = {$urandom, $urandom};
            valM = {$urandom, $urandom};
            srcA = 4'($urandom_range(0, 15));
            srcB = ($urandom_range(0, 5) == 0) ? srcA : 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (valA !== exp_rd(srcA) || valB !== exp_rd(srcB)) begin
                errors++;
                $display("FAIL rand_pre it=%0d valA=%h valB=%h want %h/%h",
                         it, valA, valB, exp_rd(srcA), exp_rd(srcB));
            end
            tick();
            checks++;
            if (valA !== exp_rd(srcA) || valB !== exp_rd(srcB) ||
                wr_cnt !== 16'(m_cnt) || conflict !== m_conf) begin
                errors++;
                $display("FAIL rand_post it=%0d valA=%h valB=%h cnt=%0d conf=%b want %h/%h/%0d/%b",
                         it, valA, valB, wr_cnt, conflict,
                         exp_rd(srcA), exp_rd(srcB), m_cnt, m_conf);
            end
        end
        idle();
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        rst = 1'b0; wr_en = 1'b1;
        for (int i = 0; i < 32767; i++) begin
            dstE = 4'(i % 15); dstM = 4'((i + 1) % 15);
            valE = 64'(i); valM = 64'(i + 1);
            tick();
        end
        dstE = 4'd10; dstM = 4'hF; valE = 64'h77;
        tick();
        checks++;
        if (wr_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preload wr_cnt=%h want ffff", wr_cnt);
        end
        dstE = 4'hF; dstM = 4'd11; valM = 64'hDEAD_BEEF_0123_4567;
        tick();
        idle();
        srcA = 4'd11;
        #1;
        checks++;
        if (wr_cnt !== 16'd0 || valA !== 64'hDEAD_BEEF_0123_4567) begin
            errors++;
            $display("FAIL wrap_zero wr_cnt=%h valA=%h want 0/deadbeef01234567", wr_cnt, valA);
        end
    endtask

    task automatic test_reset_with_write();
        wr_en = 1'b1; dstE = 4'd2; valE = 64'h11; dstM = 4'd5; valM = 64'h22;
        tick();
        rst = 1'b1; dstE = 4'd2; valE = 64'h33; dstM = 4'd2; valM = 64'h44;
        tick();
        idle();
        for (int i = 0; i < 16; i++) begin
            srcA = 4'(i); srcB = 4'(i);
            #1;
            checks++;
            if (valA !== 64'd0 || valB !== 64'd0) begin
                errors++;
                $display("FAIL rst_write_read id=%0d valA=%h valB=%h want 0", i, valA, valB);
            end
        end
        checks++;
        if (wr_cnt !== 16'd0 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL rst_write_state wr_cnt=%0d conflict=%b want 0/0", wr_cnt, conflict);
        end
    endtask

    initial begin
        for (int i = 0; i < 15; i++) m_reg[i] = 64'd0;
        m_cnt = 0; m_conf = 1'b0;
        idle();
        srcA = 4'hF; srcB = 4'hF;
        #2;
        test_reset();
        test_basic();
        test_conflict();
        test_no_bypass();
        test_wr_en_low();
        test_random();
        test_wrap();
        test_reset_with_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #2000000;
        $display("FAIL timeout sim did not finish");
        $fatal(1, "timeout");
    end

endmodule
